bits_unpacker: RTL and testbench

Parametrised bit-stream unpacker: fixed-width words are pushed into an internal word FIFO, and the requester pulls variable-length bit fields (0..OUT_W bits) out of the resulting continuous bit stream. It is the successor of the 32-in/15-out `bits` block, adding:
- configurable widths and FIFO depth;
- LSB-first or MSB-first bit order;
- input and request backpressure;
- a sticky overflow flag.

It sits between the word-level packet source and the field decoder.

---
 rtl/bits_unpacker_if.sv | 36 +++
 rtl/bits_unpacker.sv | 188 ++++++++++++++++++
 tb/tb_bits_unpacker.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bits_unpacker_if.sv
// bits_unpacker_if
// ----------------
// Bundles the word-push and field-request handshakes of bits_unpacker.
//   master : the side that pushes words and requests fields
//   slave  : the unpacker itself
// Signals:
//   pushin/datain/inready  word push handshake (word is taken when pushin && inready)
//   reqin/reqlen/reqready  field request handshake (combinational reqready)
//   pushout/lenout/dataout registered field delivery, right-aligned data
//   ovf                    sticky flag, set when a pushed word was dropped
interface bits_unpacker_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 15,
    parameter int LEN_W = 4
) ();
    logic             pushin;
    logic [IN_W-1:0]  datain;
    logic             inready;
    logic             reqin;
    logic [LEN_W-1:0] reqlen;
    logic             reqready;
    logic             pushout;
    logic [LEN_W-1:0] lenout;
    logic [OUT_W-1:0] dataout;
    logic             ovf;

    modport master (
        output pushin, datain, reqin, reqlen,
        input  inready, reqready, pushout, lenout, dataout, ovf
    );

    modport slave (
        input  pushin, datain, reqin, reqlen,
        output inready, reqready, pushout, lenout, dataout, ovf
    );
endinterface

// File: rtl/bits_unpacker.sv
// bits_unpacker
// -------------
// Turns a stream of fixed-width words into variable-length bit fields.
// Words land in a DEPTH-entry FIFO; a reservoir of IN_W+OUT_W bits is
// topped up from the FIFO head whenever it holds OUT_W bits or fewer, and
// requests of 0..OUT_W bits are served from the bottom of the reservoir.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears FIFO, reservoir and outputs
//   bus    bits_unpacker_if slave modport (push, request and output handshakes)
// Parameters:
//   IN_W, OUT_W, LEN_W (= clog2(OUT_W+1)), DEPTH (power of two),
//   MSB_FIRST (0: stream starts at datain[0], 1: at datain[IN_W-1])
module bits_unpacker #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 15,
    parameter int LEN_W     = 4,
    parameter int DEPTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    bits_unpacker_if.slave bus
);

    localparam int RES_W = IN_W + OUT_W;
    localparam int RC_W  = $clog2(RES_W + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [RC_W-1:0]  RC_OUT_W = RC_W'(OUT_W);
    localparam logic [RC_W-1:0]  RC_IN_W  = RC_W'(IN_W);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(OUT_W);

    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [IN_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;

    logic [RES_W-1:0] res_q, res_d;
    logic [RC_W-1:0]  rcount_q, rcount_d;

    logic             pushout_q, pushout_d;
    logic [LEN_W-1:0] lenout_q, lenout_d;
    logic [OUT_W-1:0] dataout_q, dataout_d;

    logic             inready;
    logic             push_ok;
    logic             pop;
    logic             accept;
    logic [LEN_W-1:0] len_eff;
    logic [IN_W-1:0]  head_raw;
    logic [IN_W-1:0]  head_rev;
    logic [IN_W-1:0]  head;
    logic [RC_W-1:0]  consumed;
    logic [RC_W-1:0]  rem;
    logic [RES_W-1:0] shifted;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] field_lsb;
    logic [OUT_W-1:0] field_rev;
    logic [OUT_W-1:0] field;

    // Request side: clamp the requested length and accept only when the
    // reservoir already holds that many bits. A zero-length request is
    // therefore always accepted, even when everything is empty.
    always_comb begin
        len_eff = (bus.reqlen > LEN_MAX) ? LEN_MAX : bus.reqlen;
        accept  = bus.reqin && (rcount_q >= RC_W'(len_eff));
    end

    // Word FIFO bookkeeping. inready looks only at registered occupancy, so
    // a full FIFO drops the incoming word even if the head leaves this cycle.
    // The refill decision uses the registered bit count, before any consume.
    always_comb begin
        inready  = (occ_q != OCC_FULL);
        push_ok  = bus.pushin && inready;
        pop      = (occ_q != '0) && (rcount_q <= RC_OUT_W);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q | (bus.pushin & ~inready);
        if (push_ok) begin
            mem_d[wr_ptr_q] = bus.datain;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Head word as it enters the reservoir. In MSB-first mode the word is
    // bit-reversed so that reservoir bit 0 is always the next stream bit.
    always_comb begin
        head_raw = mem_q[rd_ptr_q];
        head_rev = '0;
        for (int i = 0; i < IN_W; i++) begin
            head_rev[i] = head_raw[IN_W-1-i];
        end
        head = (MSB_FIRST != 0) ? head_rev : head_raw;
    end

    // Reservoir update: drop the consumed bits first, then append the head
    // word directly above whatever remains. Bits above rcount are kept zero,
    // so a plain OR is enough to merge the new word in.
    always_comb begin
        consumed = accept ? RC_W'(len_eff) : '0;
        rem      = rcount_q - consumed;
        shifted  = res_q >> consumed;
        res_d    = shifted;
        rcount_d = rem;
        if (pop) begin
            res_d    = shifted | ({{OUT_W{1'b0}}, head} << rem);
            rcount_d = rem + RC_IN_W;
        end
    end

    // Field extraction. The low len_eff bits are masked off; in MSB-first
    // mode the whole OUT_W slice is reversed and shifted back down, which
    // leaves the first stream bit at position len_eff-1.
    always_comb begin
        mask      = ~({OUT_W{1'b1}} << len_eff);
        field_lsb = res_q[OUT_W-1:0] & mask;
        field_rev = '0;
        for (int i = 0; i < OUT_W; i++) begin
            field_rev[i] = field_lsb[OUT_W-1-i];
        end
        field = (MSB_FIRST != 0) ? (field_rev >> (LEN_MAX - len_eff)) : field_lsb;
    end

    // Output stage: pushout pulses for one cycle per accepted request while
    // lenout/dataout keep the last delivered field between pulses.
    always_comb begin
        pushout_d = accept;
        lenout_d  = lenout_q;
        dataout_d = dataout_q;
        if (accept) begin
            lenout_d  = len_eff;
            dataout_d = field;
        end
    end

    // FIFO storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            rcount_q  <= '0;
            pushout_q <= 1'b0;
            lenout_q  <= '0;
            dataout_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            rcount_q  <= rcount_d;
            pushout_q <= pushout_d;
            lenout_q  <= lenout_d;
            dataout_q <= dataout_d;
        end
    end

    assign bus.inready  = inready;
    assign bus.reqready = accept;
    assign bus.pushout  = pushout_q;
    assign bus.lenout   = lenout_q;
    assign bus.dataout  = dataout_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_bits_unpacker.sv
// tb_bits_unpacker
// ----------------
// Drives two bits_unpacker instances (LSB-first and MSB-first) with directed
// vectors. Each instance has a bit-queue model of the stream that predicts
// every output on every cycle; a few hand-computed field values pin the model.
module tb_bits_unpacker;

    localparam int IN_W  = 32;
    localparam int OUT_W = 15;
    localparam int LEN_W = 4;
    localparam int DEPTH = 8;
    localparam int LOG_N = 128;

    logic clk = 1'b0;
    logic rst_n;

    logic             push_s [2];
    logic [IN_W-1:0]  data_s [2];
    logic             req_s  [2];
    logic [LEN_W-1:0] len_s  [2];
    logic             ovf_w     [2];
    logic             inready_w [2];

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [OUT_W-1:0] log_data [2][LOG_N];
    logic [LEN_W-1:0] log_len  [2][LOG_N];
    int               log_cyc  [2][LOG_N];
    int               log_n    [2] = '{0, 0};

    // Free-running clock and cycle counter used to time-stamp deliveries.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // One comparison: counts it and reports a mismatch on one line.
    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Both instances share this shape; the second one streams MSB-first.
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        bits_unpacker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) bus ();

        assign bus.pushin   = push_s[g];
        assign bus.datain   = data_s[g];
        assign bus.reqin    = req_s[g];
        assign bus.reqlen   = len_s[g];
        assign ovf_w[g]     = bus.ovf;
        assign inready_w[g] = bus.inready;

        bits_unpacker #(
            .IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W),
            .DEPTH(DEPTH), .MSB_FIRST(g)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Stream model: a queue of pending words and a queue of stream bits.
        // Outputs are compared at the falling edge, then the model advances
        // using the inputs that the next rising edge will sample.
        initial begin : model
            bit              stream [$];
            logic [IN_W-1:0] words  [$];
            bit              ovf_m;
            bit              pend;
            int              plen;
            int              pdata;
            ovf_m = 1'b0;
            pend  = 1'b0;
            plen  = 0;
            pdata = 0;
            forever begin
                @(negedge clk);
                if (bus.pushout === 1'b1 && log_n[g] < LOG_N) begin
                    log_data[g][log_n[g]] = bus.dataout;
                    log_len[g][log_n[g]]  = bus.lenout;
                    log_cyc[g][log_n[g]]  = cycle;
                    log_n[g]++;
                end
                if (!rst_n) begin
                    stream.delete();
                    words.delete();
                    ovf_m = 1'b0;
                    pend  = 1'b0;
                    checkOutput($sformatf("dut%0d reset inready", g), bus.inready, 1);
                    checkOutput($sformatf("dut%0d reset reqready", g), bus.reqready, 0);
                    checkOutput($sformatf("dut%0d reset pushout", g), bus.pushout, 0);
                    checkOutput($sformatf("dut%0d reset lenout", g), bus.lenout, 0);
                    checkOutput($sformatf("dut%0d reset dataout", g), bus.dataout, 0);
                    checkOutput($sformatf("dut%0d reset ovf", g), bus.ovf, 0);
                end else begin
                    int lim;
                    bit acc;
                    bit refill;
                    bit push_ok;
                    logic [IN_W-1:0] w;
                    lim = (int'(len_s[g]) > OUT_W) ? OUT_W : int'(len_s[g]);
                    acc = req_s[g] && (stream.size() >= lim);
                    checkOutput($sformatf("dut%0d inready", g), bus.inready, words.size() != DEPTH);
                    checkOutput($sformatf("dut%0d reqready", g), bus.reqready, acc);
                    checkOutput($sformatf("dut%0d pushout", g), bus.pushout, pend);
                    if (pend) begin
                        checkOutput($sformatf("dut%0d lenout", g), bus.lenout, plen);
                        checkOutput($sformatf("dut%0d dataout", g), bus.dataout, pdata);
                    end
                    checkOutput($sformatf("dut%0d ovf", g), bus.ovf, ovf_m);

                    refill  = (words.size() != 0) && (stream.size() <= OUT_W);
                    push_ok = push_s[g] && (words.size() != DEPTH);
                    if (push_s[g] && !push_ok) ovf_m = 1'b1;
                    pend = acc;
                    if (acc) begin
                        plen  = lim;
                        pdata = 0;
                        for (int i = 0; i < lim; i++) begin
                            int b;
                            b = int'(stream.pop_front());
                            if (g == 1) pdata = pdata | (b << (lim - 1 - i));
                            else        pdata = pdata | (b << i);
                        end
                    end
                    if (refill) begin
                        w = words.pop_front();
                        for (int i = 0; i < IN_W; i++) begin
                            if (g == 1) stream.push_back(w[IN_W-1-i]);
                            else        stream.push_back(w[i]);
                        end
                    end
                    if (push_ok) words.push_back(data_s[g]);
                end
            end
        end
    end

    // Drives one cycle of inputs to the selected instance; the other idles.
    task automatic applyStimulus(input int sel, input bit push, input logic [IN_W-1:0] data,
                                 input bit req, input logic [LEN_W-1:0] len);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            push_s[k] = 1'b0;
            data_s[k] = '0;
            req_s[k]  = 1'b0;
            len_s[k]  = '0;
        end
        push_s[sel] = push;
        data_s[sel] = data;
        req_s[sel]  = req;
        len_s[sel]  = len;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic doReset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_s[k] = 1'b0;
            data_s[k] = '0;
            req_s[k]  = 1'b0;
            len_s[k]  = '0;
        end
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Compares one logged delivery against hand-computed values.
    task automatic expectLog(input int sel, input int idx, input int len, input int data,
                             input string name);
        if (idx >= log_n[sel]) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no delivery, expected len %0d data 0x%0h", name, len, data);
        end else begin
            checkOutput({name, " len"}, log_len[sel][idx], len);
            checkOutput({name, " data"}, log_data[sel][idx], data);
        end
    endtask

    // Directed scenarios, each starting from a fresh reset.
    initial begin
        int base;
        int t;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_s[k] = 1'b0;
            data_s[k] = '0;
            req_s[k]  = 1'b0;
            len_s[k]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] underflow stall and zero length");
        base = log_n[0];
        repeat (4) applyStimulus(0, 1'b0, '0, 1'b1, 4'd5);
        idle(3);
        checkOutput("stall no delivery", log_n[0] - base, 0);
        applyStimulus(0, 1'b0, '0, 1'b1, 4'd0);
        t = cycle;
        idle(3);
        expectLog(0, base, 0, 0, "zero-length field");
        if (log_n[0] > base) checkOutput("zero-length latency", log_cyc[0][base], t + 1);
        applyStimulus(0, 1'b1, 32'hDEADBEEF, 1'b1, 4'd5);
        t = cycle;
        applyStimulus(0, 1'b0, '0, 1'b1, 4'd5);
        applyStimulus(0, 1'b0, '0, 1'b1, 4'd5);
        idle(3);
        expectLog(0, base + 1, 5, 'h0F, "first field after push");
        if (log_n[0] > base + 1) checkOutput("push-to-pushout latency", log_cyc[0][base+1], t + 3);
        checkOutput("stall delivery count", log_n[0] - base, 2);

        $display("[TB] LSB-first fields");
        doReset(2);
        base = log_n[0];
        applyStimulus(0, 1'b1, 32'hDEADBEEF, 1'b0, '0);
        idle(1);
        applyStimulus(0, 1'b0, '0, 1'b1, 4'd4);
        applyStimulus(0, 1'b0, '0, 1'b1, 4'd12);
        idle(3);
        expectLog(0, base, 4, 'h000F, "lsb field 4");
        expectLog(0, base + 1, 12, 'h0BEE, "lsb field 12");

        $display("[TB] word crossing");
        doReset(2);
        base = log_n[0];
        applyStimulus(0, 1'b1, 32'hDEADBEEF, 1'b0, '0);
        applyStimulus(0, 1'b1, 32'h12345678, 1'b0, '0);
        idle(1);
        repeat (5) applyStimulus(0, 1'b0, '0, 1'b1, 4'd15);
        idle(3);
        expectLog(0, base, 15, 'h3EEF, "crossing field 1");
        expectLog(0, base + 1, 15, 'h3D5B, "crossing field 2");
        expectLog(0, base + 2, 15, 'h59E3, "crossing field 3");
        expectLog(0, base + 3, 15, 'h11A2, "crossing field 4");
        repeat (2) applyStimulus(0, 1'b0, '0, 1'b1, 4'd5);
        idle(3);
        checkOutput("crossing delivery count", log_n[0] - base, 4);

        $display("[TB] overflow");
        doReset(2);
        base = log_n[0];
        for (int i = 0; i < 10; i++) applyStimulus(0, 1'b1, 32'hA5000000 | i, 1'b0, '0);
        idle(2);
        checkOutput("ovf after drop", ovf_w[0], 1);
        checkOutput("inready while full", inready_w[0], 0);
        repeat (40) applyStimulus(0, 1'b0, '0, 1'b1, 4'd15);
        idle(3);
        checkOutput("drained field count", log_n[0] - base, 19);
        expectLog(0, base + 1, 15, 'h4A00, "drained field 2");
        checkOutput("ovf sticky", ovf_w[0], 1);

        $display("[TB] MSB-first");
        doReset(2);
        base = log_n[1];
        applyStimulus(1, 1'b1, 32'hA0000000, 1'b0, '0);
        idle(1);
        applyStimulus(1, 1'b0, '0, 1'b1, 4'd3);
        applyStimulus(1, 1'b0, '0, 1'b1, 4'd2);
        idle(3);
        expectLog(1, base, 3, 'h5, "msb field 3");
        expectLog(1, base + 1, 2, 'h0, "msb field 2");
        applyStimulus(1, 1'b1, 32'hDEADBEEF, 1'b0, '0);
        idle(1);
        repeat (3) applyStimulus(1, 1'b0, '0, 1'b1, 4'd15);
        idle(3);
        expectLog(1, base + 2, 15, 'h0000, "msb zeros field");
        expectLog(1, base + 3, 15, 'h0006, "msb crossing field");

        $display("[TB] reset mid-stream");
        doReset(2);
        base = log_n[0];
        applyStimulus(0, 1'b1, 32'hDEADBEEF, 1'b0, '0);
        idle(1);
        applyStimulus(0, 1'b0, '0, 1'b1, 4'd4);
        idle(1);
        doReset(2);
        repeat (5) applyStimulus(0, 1'b0, '0, 1'b1, 4'd1);
        idle(3);
        checkOutput("no delivery after reset", log_n[0] - base, 1);
        applyStimulus(0, 1'b1, 32'h00000001, 1'b1, 4'd1);
        t = cycle;
        applyStimulus(0, 1'b0, '0, 1'b1, 4'd1);
        applyStimulus(0, 1'b0, '0, 1'b1, 4'd1);
        idle(3);
        expectLog(0, base + 1, 1, 'h1, "post-reset field");
        if (log_n[0] > base + 1) checkOutput("post-reset latency", log_cyc[0][base+1], t + 3);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the scenario sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
